// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: FSM state encoding,
// default geometry and the wait-counter width.
package mcrp_mem_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter preload for a given latency; WAIT lasts exactly LATENCY cycles.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    if (lat > 0) begin
      return CNT_W'(lat - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the processor memory port (master) and the
// responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready. The
// sender keeps valid and its payload stable until the transfer edge, and the
// receiver may raise or drop ready freely; ready never depends on valid.
interface data_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// Word storage for the responder: synchronous write, registered read, no reset.
module mem_word_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: accepts a load/store, waits LATENCY
// cycles, commits to the array, then holds the response until it is taken.
module data_mem_responder
  import mcrp_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output state_t               dbg_state
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = lat_to_cnt(LATENCY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic              rd_sel_q, rd_sel_d;

  logic              commit;
  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_in_range;
  logic [IDX_W-1:0]  c_idx;
  logic              arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_err_d   = resp_err_q;
    rd_sel_d     = rd_sel_q;
    commit       = 1'b0;
    c_write      = wr_q;
    c_addr       = addr_q;
    c_wdata      = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 0) begin
            // Zero wait: commit straight from the bus on the accept edge.
            commit  = 1'b1;
            c_write = bus.req_write;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            state_d = RESP;
          end else begin
            cnt_d   = LAT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Range check spans the full address; only the low bits index the array.
    c_in_range = (64'(c_addr) < 64'(DEPTH));
    c_idx      = c_addr[IDX_W-1:0];
    arr_we     = commit && c_write && c_in_range;
    arr_re     = commit && !c_write && c_in_range;

    if (commit) begin
      resp_err_d = !c_in_range;
      rd_sel_d   = !c_write && c_in_range;
    end else if (state_d == IDLE) begin
      resp_err_d = 1'b0;
      rd_sel_d   = 1'b0;
    end

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      rd_sel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      rd_sel_q     <= rd_sel_d;
    end
  end

  mem_word_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (c_idx),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  // The array read register is only exposed for in-range loads.
  assign bus.resp_rdata = rd_sel_q ? arr_rdata : '0;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 2, 0, 4)
// checked every cycle against a transaction-level model plus literal checks.
module tb_data_mem_responder;
  import mcrp_mem_pkg::*;

  localparam int NDUT = 3;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int DEP  = 256;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid  = 1'b0;
  logic          req_write  = 1'b0;
  logic [AW-1:0] req_addr   = '0;
  logic [DW-1:0] req_wdata  = '0;
  logic          resp_ready = 1'b1;
  int            act        = 0;

  logic [NDUT-1:0] o_req_ready, o_resp_valid, o_resp_err, o_busy;
  logic [DW-1:0]   o_rdata [NDUT];
  state_t          o_state [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    assign bus.req_valid  = req_valid && (act == g);
    assign bus.req_write  = req_write;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.resp_ready = resp_ready;
    assign o_req_ready[g]  = bus.req_ready;
    assign o_resp_valid[g] = bus.resp_valid;
    assign o_resp_err[g]   = bus.resp_err;
    assign o_busy[g]       = bus.busy;
    assign o_rdata[g]      = bus.resp_rdata;

    data_mem_responder #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .DEPTH   (DEP),
      .LATENCY ((g == 0) ? 2 : ((g == 1) ? 0 : 4))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (o_state[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endfunction

  // Model: one outstanding transaction per instance, response due LATENCY+1
  // cycles after the accept cycle, commit applied when the response becomes due.
  logic [DW-1:0] mdl_mem [NDUT][DEP];
  logic          m_pend  [NDUT] = '{default: 1'b0};
  logic          m_done  [NDUT] = '{default: 1'b0};
  int            m_acc   [NDUT] = '{default: 0};
  logic          m_wr    [NDUT] = '{default: 1'b0};
  logic [AW-1:0] m_addr  [NDUT] = '{default: '0};
  logic [DW-1:0] m_wdata [NDUT] = '{default: '0};
  logic [DW-1:0] m_rdata [NDUT] = '{default: '0};
  logic          m_err   [NDUT] = '{default: 1'b0};
  logic [DW-1:0] exp_q [$];
  int            cyc    = 0;
  bit            chk_en = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < NDUT; d++) m_pend[d] = 1'b0;
      if (chk_en) begin
        chk("rst_req_ready", o_req_ready[act], 1'b1);
        chk("rst_resp_valid", o_resp_valid[act], 1'b0);
        chk("rst_busy", o_busy[act], 1'b0);
        chk("rst_err", o_resp_err[act], 1'b0);
      end
    end else if (chk_en) begin
      automatic int   d   = act;
      automatic logic due = m_pend[d] && (cyc >= m_acc[d] + lat_of(d) + 1);
      if (due && !m_done[d]) begin
        m_done[d] = 1'b1;
        m_err[d]  = (m_addr[d] >= AW'(DEP));
        if (m_err[d]) m_rdata[d] = '0;
        else if (m_wr[d]) begin
          mdl_mem[d][m_addr[d][7:0]] = m_wdata[d];
          m_rdata[d] = '0;
        end else m_rdata[d] = mdl_mem[d][m_addr[d][7:0]];
        exp_q.push_back(m_rdata[d]);
      end
      chk("req_ready", o_req_ready[d], !m_pend[d]);
      chk("busy", o_busy[d], m_pend[d]);
      chk("resp_valid", o_resp_valid[d], due);
      if (due) begin
        chk("resp_rdata", o_rdata[d], m_rdata[d]);
        chk("resp_err", o_resp_err[d], m_err[d]);
      end else begin
        chk("resp_err_idle", o_resp_err[d], 1'b0);
      end
      if (due && resp_ready) begin
        m_pend[d] = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!m_pend[d] && req_valid) begin
        m_pend[d]  = 1'b1;
        m_done[d]  = 1'b0;
        m_acc[d]   = cyc;
        m_wr[d]    = req_write;
        m_addr[d]  = req_addr;
        m_wdata[d] = req_wdata;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int d, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, output int acc);
    int n;
    n   = 0;
    act = d;
    while (o_req_ready[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    acc       = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int d, input int acc, input string name, input int exp_lat,
                           input logic [DW-1:0] exp_rd, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (o_resp_valid[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_lat"}, 64'(cyc - 1 - acc), 64'(exp_lat));
    chk({name, "_rdata"}, o_rdata[d], exp_rd);
    chk({name, "_err"}, o_resp_err[d], exp_err);
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int a0, a1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("init_req_ready", o_req_ready[d], 1'b1);
      chk("init_resp_valid", o_resp_valid[d], 1'b0);
      chk("init_busy", o_busy[d], 1'b0);
      chk("init_rdata", o_rdata[d], '0);
      chk("init_err", o_resp_err[d], 1'b0);
    end
    @(posedge clk);
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // LATENCY=2: store then load, accept to accept LATENCY+2
    send(0, 1'b1, 32'd5, 32'hDEADBEEF, a0);
    wait_resp(0, a0, "l2_store", 3, 32'h0, 1'b0);
    send(0, 1'b0, 32'd5, 32'h0, a1);
    chk("l2_acc_to_acc", 64'(a1 - a0), 64'd4);
    wait_resp(0, a1, "l2_load", 3, 32'hDEADBEEF, 1'b0);

    // LATENCY=0
    send(1, 1'b1, 32'd5, 32'h55AA0001, a0);
    wait_resp(1, a0, "l0_store", 1, 32'h0, 1'b0);
    send(1, 1'b0, 32'd5, 32'h0, a1);
    chk("l0_ready_low", o_req_ready[1], 1'b0);
    wait_resp(1, a1, "l0_load", 1, 32'h55AA0001, 1'b0);
    chk("l0_ready_back", o_req_ready[1], 1'b1);
    chk("l0_acc_to_acc", 64'(a1 - a0), 64'd2);

    // Backpressure: resp_ready low for 5 response cycles, req_valid pulses ignored
    resp_ready = 1'b0;
    send(0, 1'b0, 32'd5, 32'h0, a0);
    @(negedge clk); #1;
    while (o_resp_valid[0] !== 1'b1 && (cyc - a0) < 50) begin
      @(negedge clk); #1;
    end
    chk("bp_first_rdata", o_rdata[0], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      req_valid = (i % 2 == 0);
      req_addr  = 32'd9;
      @(negedge clk); #1;
      chk("bp_valid_hold", o_resp_valid[0], 1'b1);
      chk("bp_rdata_hold", o_rdata[0], 32'hDEADBEEF);
      chk("bp_no_accept", o_req_ready[0], 1'b0);
    end
    @(posedge clk); #2;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_last_valid", o_resp_valid[0], 1'b1);
    @(negedge clk); #1;
    chk("bp_done_valid", o_resp_valid[0], 1'b0);
    chk("bp_done_ready", o_req_ready[0], 1'b1);
    @(posedge clk); #2;

    // Out of range on DEPTH=256
    send(0, 1'b1, 32'd0, 32'hCAFE0000, a0);
    wait_resp(0, a0, "oor_pre", 3, 32'h0, 1'b0);
    send(0, 1'b1, 32'd256, 32'h12345678, a0);
    wait_resp(0, a0, "oor_store", 3, 32'h0, 1'b1);
    send(0, 1'b0, 32'd0, 32'h0, a0);
    wait_resp(0, a0, "oor_alias", 3, 32'hCAFE0000, 1'b0);
    send(0, 1'b0, 32'h8000_0005, 32'h0, a0);
    wait_resp(0, a0, "oor_load_hi", 3, 32'h0, 1'b1);

    // Reset two cycles into WAIT (LATENCY=4) drops the store
    send(2, 1'b1, 32'd7, 32'h11111111, a0);
    wait_resp(2, a0, "l4_store", 5, 32'h0, 1'b0);
    send(2, 1'b1, 32'd7, 32'hA5A5A5A5, a0);
    tick();
    reset = 1'b1;
    #1;
    chk("rstw_resp_valid", o_resp_valid[2], 1'b0);
    chk("rstw_req_ready", o_req_ready[2], 1'b1);
    chk("rstw_busy", o_busy[2], 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    tick();
    send(2, 1'b0, 32'd7, 32'h0, a0);
    wait_resp(2, a0, "rstw_load", 5, 32'h11111111, 1'b0);

    // Back-to-back stores then loads, LATENCY=2
    a1 = -1;
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b1, AW'(i), DW'(i + 1), a0);
      if (a1 >= 0) chk("b2b_store_gap", 64'(a0 - a1), 64'd4);
      a1 = a0;
      wait_resp(0, a0, "b2b_store", 3, 32'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, AW'(i), 32'h0, a0);
      chk("b2b_load_gap", 64'(a0 - a1), 64'd4);
      a1 = a0;
      wait_resp(0, a0, "b2b_load", 3, DW'(i + 1), 1'b0);
    end

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
